alu_bist: RTL and testbench

Hardware self-test sequencer for the 4-bit ALU (`lab5_1` interface: `x`, `y`, `select` in; `out`, `c_out` back). On `start` it drives all 3072 operand/opcode combinations, covering 12 opcodes × 16 x × 16 y. It compares each ALU response against an internal golden model and reports pass/fail counts plus the first failing vector. It sits on the stimulus side of the ALU and replaces the simulation-only bench for on-board checking.

---
 rtl/alu_bist_pkg.sv | 42 ++++
 rtl/alu_golden.sv | 47 ++++
 rtl/alu_bist.sv | 156 +++++++++++++++
 tb/tb_alu_bist.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU self-test sequencer: opcode constants,
// sweep sizes, FSM state encoding and the {sel, x, y} vector layout.
package alu_bist_pkg;

  localparam int unsigned DATA_W    = 4;
  localparam int unsigned SEL_W     = 4;
  localparam int unsigned VEC_W     = SEL_W + 2 * DATA_W;
  localparam int unsigned CNT_W     = 12;
  localparam int unsigned NUM_SEL   = 12;
  localparam int unsigned VEC_TOTAL = NUM_SEL * (1 << (2 * DATA_W));

  localparam logic [SEL_W-1:0] SEL_TRANSFER     = 4'h0;
  localparam logic [SEL_W-1:0] SEL_INC          = 4'h1;
  localparam logic [SEL_W-1:0] SEL_ADD          = 4'h2;
  localparam logic [SEL_W-1:0] SEL_ADD_INC      = 4'h3;
  localparam logic [SEL_W-1:0] SEL_SUB1         = 4'h4;
  localparam logic [SEL_W-1:0] SEL_SUB2         = 4'h5;
  localparam logic [SEL_W-1:0] SEL_DEC          = 4'h6;
  localparam logic [SEL_W-1:0] SEL_DEC_TRANSFER = 4'h7;
  localparam logic [SEL_W-1:0] SEL_AND          = 4'h8;
  localparam logic [SEL_W-1:0] SEL_OR           = 4'h9;
  localparam logic [SEL_W-1:0] SEL_XOR          = 4'hA;
  localparam logic [SEL_W-1:0] SEL_NOT          = 4'hB;

  // Index of the final vector (sel=0xB, x=15, y=15)
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(VEC_TOTAL - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // y is the least significant field so a plain increment walks y innermost
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
  } vec_t;

endpackage

// File: rtl/alu_golden.sv
// Combinational reference for the 4-bit ALU.
// Ports: i_x, i_y, i_sel  - operands and opcode under test
//        o_exp_out        - expected 4-bit result
//        o_exp_c_out      - expected carry-out (meaningful for arithmetic ops)
//        o_cmp_c          - high when carry-out takes part in the compare
module alu_golden
  import alu_bist_pkg::*;
(
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_y,
  input  logic [SEL_W-1:0]  i_sel,
  output logic [DATA_W-1:0] o_exp_out,
  output logic              o_exp_c_out,
  output logic              o_cmp_c
);

  logic [DATA_W-1:0] w_b;
  logic              w_cin;
  logic [DATA_W:0]   w_sum;

  // Arithmetic ops are all x + B + cin; cin is the opcode LSB
  always_comb begin
    w_b   = '0;
    w_cin = i_sel[0];
    case (i_sel)
      SEL_ADD, SEL_ADD_INC:  w_b = i_y;
      SEL_SUB1, SEL_SUB2:    w_b = ~i_y;
      SEL_DEC, SEL_DEC_TRANSFER: w_b = '1;
      default:               w_b = '0;
    endcase
    w_sum = {1'b0, i_x} + {1'b0, w_b} + (DATA_W + 1)'(w_cin);
  end

  always_comb begin
    o_exp_out   = w_sum[DATA_W-1:0];
    o_exp_c_out = w_sum[DATA_W];
    o_cmp_c     = ~i_sel[SEL_W-1];
    case (i_sel)
      SEL_AND: o_exp_out = i_x & i_y;
      SEL_OR:  o_exp_out = i_x | i_y;
      SEL_XOR: o_exp_out = i_x ^ i_y;
      SEL_NOT: o_exp_out = ~i_x;
      default: o_exp_out = w_sum[DATA_W-1:0];
    endcase
  end

endmodule

// File: rtl/alu_bist.sv
// Self-test sequencer for the 4-bit ALU: sweeps all 12 x 16 x 16 vectors,
// compares each response with alu_golden and reports counts plus the first
// failing vector.
// Ports: clk, reset_n (async active-low), start, abort   - control
//        alu_x, alu_y, alu_select (registered)           - stimulus to ALU
//        alu_out, alu_c_out                              - ALU response
//        busy, done                                      - sweep status
//        pass_cnt, fail_cnt                              - result counts
//        have_fail, ff_sel, ff_x, ff_y                   - first failure
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [SEL_W-1:0]  alu_select,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_c_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              have_fail,
  output logic [SEL_W-1:0]  ff_sel,
  output logic [DATA_W-1:0] ff_x,
  output logic [DATA_W-1:0] ff_y
);

  localparam int unsigned        SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0]   SET_LAST = SET_W'(SETTLE - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  vec_t              r_vec;
  vec_t              r_ff;
  logic [SET_W-1:0]  r_settle;
  logic [CNT_W-1:0]  r_pass;
  logic [CNT_W-1:0]  r_fail;
  logic              r_have_fail;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_commit;
  logic              w_match;
  logic [DATA_W-1:0] w_exp_out;
  logic              w_exp_c_out;
  logic              w_cmp_c;

  alu_golden u_golden (
    .i_x        (r_vec.x),
    .i_y        (r_vec.y),
    .i_sel      (r_vec.sel),
    .o_exp_out  (w_exp_out),
    .o_exp_c_out(w_exp_c_out),
    .o_cmp_c    (w_cmp_c)
  );

  // Case equality so that X/Z on a compared ALU bit never counts as a match
  assign w_match = (alu_out === w_exp_out) &&
                   (!w_cmp_c || (alu_c_out === w_exp_c_out));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode; w_commit marks a CHECK closing edge that counts
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (abort)                      w_state_nxt = ST_IDLE;
        else if (r_settle == SET_LAST)  w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = (r_vec == VEC_LAST) ? ST_DONE : ST_DRIVE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Status flags follow the next state so they change on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_settle <= '0;
    end else begin
      r_busy   <= (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_CHECK);
      r_done   <= (w_state_nxt == ST_DONE);
      r_settle <= ((r_state == ST_DRIVE) && (w_state_nxt == ST_DRIVE)) ?
                  r_settle + SET_W'(1) : '0;
    end
  end

  // Vector walker, result counters and first-failure capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vec       <= '0;
      r_ff        <= '0;
      r_pass      <= '0;
      r_fail      <= '0;
      r_have_fail <= 1'b0;
    end else if (w_accept) begin
      r_vec       <= '0;
      r_ff        <= '0;
      r_pass      <= '0;
      r_fail      <= '0;
      r_have_fail <= 1'b0;
    end else if (w_commit) begin
      if (w_match) begin
        r_pass <= r_pass + CNT_W'(1);
      end else begin
        r_fail <= r_fail + CNT_W'(1);
        if (!r_have_fail) begin
          r_have_fail <= 1'b1;
          r_ff        <= r_vec;
        end
      end
      if (r_vec != VEC_LAST) r_vec <= vec_t'(r_vec + VEC_W'(1));
    end
  end

  assign alu_x      = r_vec.x;
  assign alu_y      = r_vec.y;
  assign alu_select = r_vec.sel;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass_cnt   = r_pass;
  assign fail_cnt   = r_fail;
  assign have_fail  = r_have_fail;
  assign ff_sel     = r_ff.sel;
  assign ff_x       = r_ff.x;
  assign ff_y       = r_ff.y;

endmodule

// File: tb/tb_alu_bist.sv
// Directed/randomised bench for alu_bist with a behavioural ALU (faults
// selectable by mode) and an arithmetic reference model of the sweep.
module tb_alu_bist;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [3:0] alu_x, alu_y, alu_select, alu_out;
  logic       alu_c_out;
  logic       busy, done, have_fail;
  logic [11:0] pass_cnt, fail_cnt;
  logic [3:0] ff_sel, ff_x, ff_y;

  int n_checks = 0;
  int n_fail   = 0;

  // 0 good, 1 c_out stuck 0, 2 out[0] inverted on NOT, 3 random flips, 4 X inject
  int mode = 0;
  bit gar  [3072];
  bit flip [3072];
  int xk   = 0;

  alu_bist #(.SETTLE(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .alu_x(alu_x), .alu_y(alu_y), .alu_select(alu_select),
    .alu_out(alu_out), .alu_c_out(alu_c_out),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .have_fail(have_fail), .ff_sel(ff_sel), .ff_x(ff_x), .ff_y(ff_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {c_out, out} for an ideal ALU
  function automatic logic [4:0] golden(int s, int x, int y);
    int b, sum;
    case (s)
      8:  return {1'b0, 4'(x & y)};
      9:  return {1'b0, 4'(x | y)};
      10: return {1'b0, 4'(x ^ y)};
      11: return {1'b0, 4'(~x & 15)};
      default: begin
        case (s / 2)
          0: b = 0;
          1: b = y;
          2: b = 15 - y;
          default: b = 15;
        endcase
        sum = x + b + (s % 2);
        return 5'(sum);
      end
    endcase
  endfunction

  // Behavioural ALU under test, including the injected fault for this mode
  function automatic logic [4:0] alu_resp(int m, int idx);
    logic [4:0] r;
    int s, x, y;
    s = idx / 256;
    x = (idx / 16) % 16;
    y = idx % 16;
    r = golden(s, x, y);
    if (s >= 8) r[4] = gar[idx];
    case (m)
      1: if (s < 8) r[4] = 1'b0;
      2: if (s == 11) r[0] = ~r[0];
      3: if (flip[idx]) r[3:0] = r[3:0] ^ 4'(1 << (idx % 4));
      4: begin
        if (idx == xk) r[3:0] = 4'bxxxx;
        if (s >= 8) r[4] = 1'bx;
      end
      default: ;
    endcase
    return r;
  endfunction

  always_comb {alu_c_out, alu_out} = alu_resp(mode, int'({alu_select, alu_x, alu_y}));

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference sweep: walk every vector in order and apply the match rule
  task automatic model(int m, output int ep, output int ef, output int ehf,
                       output int es, output int ex, output int ey);
    logic [4:0] g, a;
    bit ok;
    ep = 0; ef = 0; ehf = 0; es = 0; ex = 0; ey = 0;
    for (int idx = 0; idx < 3072; idx++) begin
      g  = golden(idx / 256, (idx / 16) % 16, idx % 16);
      a  = alu_resp(m, idx);
      ok = (a[3:0] === g[3:0]) && ((idx / 256) >= 8 || a[4] === g[4]);
      if (ok) ep++;
      else begin
        ef++;
        if (ehf == 0) begin
          ehf = 1; es = idx / 256; ex = (idx / 16) % 16; ey = idx % 16;
        end
      end
    end
  endtask

  function automatic int cur_vec();
    return int'({alu_select, alu_x, alu_y});
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_vec(string tag, int k);
    int cyc = 0;
    while (cur_vec() != k && cyc < 10000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(tag, cur_vec(), k);
  endtask

  // Start a sweep, verify the cleared state, and time it to done
  task automatic run_sweep(string tag);
    int cyc = 0;
    pulse_start();
    check({tag, "_busy0"}, busy, 1);
    check({tag, "_done0"}, done, 0);
    check({tag, "_vec0"}, cur_vec(), 0);
    check({tag, "_clr"}, {pass_cnt, fail_cnt, 3'b0, have_fail, ff_sel, ff_x, ff_y}, 0);
    while (!done && cyc < 8000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_cycles"}, cyc, 6144);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_sum"}, pass_cnt + fail_cnt, 3072);
  endtask

  task automatic check_model(string tag);
    int ep, ef, ehf, es, ex, ey;
    model(mode, ep, ef, ehf, es, ex, ey);
    check({tag, "_pass"}, pass_cnt, ep);
    check({tag, "_fail"}, fail_cnt, ef);
    check({tag, "_hf"}, have_fail, ehf);
    check({tag, "_ff"}, {ff_sel, ff_x, ff_y}, {4'(es), 4'(ex), 4'(ey)});
  endtask

  initial begin
    int k;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    for (int i = 0; i < 3072; i++) begin
      gar[i]  = 1'($urandom);
      flip[i] = ($urandom_range(63) == 0);
    end
    xk = $urandom_range(3071);

    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {alu_select, alu_x, alu_y, 2'b0, busy, done}, 0);
    check("rst_cnts", {pass_cnt, fail_cnt, 3'b0, have_fail, ff_sel, ff_x, ff_y}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Good ALU
    mode = 0;
    run_sweep("good");
    check("good_pass", pass_cnt, 3072);
    check("good_fail", fail_cnt, 0);
    check_model("good");

    // c_out stuck at 0, then restart from DONE and reproduce
    mode = 1;
    run_sweep("cstuck");
    check("cstuck_fail", fail_cnt, 1024);
    check("cstuck_pass", pass_cnt, 2048);
    check("cstuck_ff", {have_fail, ff_sel, ff_x, ff_y}, {1'b1, 4'h1, 4'hF, 4'h0});
    run_sweep("restart");
    check("restart_fail", fail_cnt, 1024);
    check("restart_ff", {have_fail, ff_sel, ff_x, ff_y}, {1'b1, 4'h1, 4'hF, 4'h0});

    // out[0] inverted on NOT only, garbage carry on logic ops
    mode = 2;
    run_sweep("notbit");
    check("notbit_fail", fail_cnt, 256);
    check("notbit_ff", {have_fail, ff_sel, ff_x, ff_y}, {1'b1, 4'hB, 4'h0, 4'h0});
    check_model("notbit");

    // Random result-bit faults
    mode = 3;
    run_sweep("rflip");
    check_model("rflip");

    // X on one result, X carry on all logic ops
    mode = 4;
    run_sweep("xinj");
    check_model("xinj");

    // Start while busy is ignored; abort during vector 100's DRIVE
    mode = 1;
    pulse_start();
    wait_vec("wait50", 50);
    pulse_start();
    @(posedge clk); #1;
    check("ign_start_vec", cur_vec(), 51);
    check("ign_start_busy", busy, 1);
    wait_vec("wait100", 100);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", pass_cnt + fail_cnt, 100);
    @(posedge clk); #1;
    check("abort_hold", {busy, done, 4'(0), 12'(cur_vec())}, {1'b0, 1'b0, 4'(0), 12'd100});

    // Abort in a CHECK cycle at a random vector: that vector is not counted
    k = $urandom_range(3000, 1);
    pulse_start();
    wait_vec("waitk", k);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abortchk_sum", pass_cnt + fail_cnt, k);
    check("abortchk_st", {busy, done}, 0);

    // Asynchronous reset mid-sweep, then a clean restart
    k = $urandom_range(3000, 300);
    pulse_start();
    wait_vec("waitr", k);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_outs", {alu_select, alu_x, alu_y, 2'b0, busy, done}, 0);
    check("midrst_cnts", {pass_cnt, fail_cnt, 3'b0, have_fail, ff_sel, ff_x, ff_y}, 0);
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_sweep("postrst");
    check_model("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
